// File: rtl/count_blinker.sv
// ---------------------------------------------------------------------------
// count_blinker
//
// Purpose:
//   Turns a 4-bit count into a train of LED pulses so the game can show a
//   number as N blinks. One accepted start strobe produces one complete frame:
//   N pulses of ON_CYCLES high separated by OFF_CYCLES low, then a trailing
//   GAP_CYCLES low gap, then a one-cycle done pulse. A count of zero produces
//   only the trailing gap.
//
// Parameters:
//   ON_CYCLES   clocks the LED is high per pulse            (1..255)
//   OFF_CYCLES  clocks the LED is low between pulses        (1..255)
//   GAP_CYCLES  clocks of trailing low gap before done      (1..255)
//
// Ports:
//   clk        in   1  clock, all logic on the rising edge
//   rst        in   1  synchronous reset, active-low
//   start      in   1  frame request, sampled only while idle
//   value      in   4  number of pulses, captured when start is accepted
//   led        out  1  registered pulse train
//   busy       out  1  high while a frame is in progress
//   done       out  1  one-cycle pulse in the first idle cycle after a frame
//   remaining  out  4  pulses not yet started in the current frame
// ---------------------------------------------------------------------------
module count_blinker #(
  parameter int ON_CYCLES  = 8,
  parameter int OFF_CYCLES = 8,
  parameter int GAP_CYCLES = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [3:0] value,
  output logic       led,
  output logic       busy,
  output logic       done,
  output logic [3:0] remaining
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] ON   = 2'd1;
  localparam logic [1:0] OFF  = 2'd2;
  localparam logic [1:0] GAP  = 2'd3;

  // The timer is loaded with length-1 and the phase ends on the edge where it
  // reads zero, so a phase lasts exactly its parameter in cycles.
  localparam logic [7:0] ON_LOAD  = 8'(ON_CYCLES - 1);
  localparam logic [7:0] OFF_LOAD = 8'(OFF_CYCLES - 1);
  localparam logic [7:0] GAP_LOAD = 8'(GAP_CYCLES - 1);

  logic [1:0] state;
  logic [1:0] state_next;
  logic [7:0] timer;
  logic [7:0] timer_next;
  logic       timer_zero;
  logic       led_next;
  logic       busy_next;
  logic       done_next;
  logic [3:0] remaining_next;

  assign timer_zero = (timer == 8'd0);

  // Next-state logic. Every output is computed here and registered below, so
  // led/busy/done/remaining change only on clock edges and have no
  // combinational path from start or value.
  always_comb begin
    state_next     = state;
    timer_next     = timer;
    led_next       = led;
    busy_next      = busy;
    done_next      = 1'b0;
    remaining_next = remaining;

    case (state)
      IDLE: begin
        led_next  = 1'b0;
        busy_next = 1'b0;
        if (start) begin
          busy_next = 1'b1;
          if (value != 4'd0) begin
            // The first pulse starts on the accept edge, so it already counts
            // as started and remaining drops by one immediately.
            state_next     = ON;
            led_next       = 1'b1;
            remaining_next = value - 4'd1;
            timer_next     = ON_LOAD;
          end else begin
            state_next     = GAP;
            led_next       = 1'b0;
            remaining_next = 4'd0;
            timer_next     = GAP_LOAD;
          end
        end
      end

      ON: begin
        if (timer_zero) begin
          led_next = 1'b0;
          if (remaining != 4'd0) begin
            state_next = OFF;
            timer_next = OFF_LOAD;
          end else begin
            state_next = GAP;
            timer_next = GAP_LOAD;
          end
        end else begin
          timer_next = timer - 8'd1;
        end
      end

      OFF: begin
        if (timer_zero) begin
          state_next     = ON;
          led_next       = 1'b1;
          remaining_next = remaining - 4'd1;
          timer_next     = ON_LOAD;
        end else begin
          timer_next = timer - 8'd1;
        end
      end

      GAP: begin
        if (timer_zero) begin
          // busy falls on the same edge that done rises.
          state_next = IDLE;
          busy_next  = 1'b0;
          done_next  = 1'b1;
        end else begin
          timer_next = timer - 8'd1;
        end
      end

      default: begin
        state_next     = IDLE;
        led_next       = 1'b0;
        busy_next      = 1'b0;
        remaining_next = 4'd0;
        timer_next     = 8'd0;
      end
    endcase
  end

  // State and output registers. Reset is synchronous and aborts any frame in
  // progress without a done pulse; the LED drops on the reset edge.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= IDLE;
      timer     <= 8'd0;
      led       <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      remaining <= 4'd0;
    end else begin
      state     <= state_next;
      timer     <= timer_next;
      led       <= led_next;
      busy      <= busy_next;
      done      <= done_next;
      remaining <= remaining_next;
    end
  end

endmodule

// File: tb/tb_count_blinker.sv
// ---------------------------------------------------------------------------
// tb_count_blinker
//
// Drives two count_blinker instances: dutA with default timing and dutB with
// ON=OFF=GAP=1. When a frame is requested, the whole expected per-cycle output
// sequence ({led,busy,done,remaining}) is built from the frame formulas and
// pushed to that instance's queue; every cycle one entry is popped and
// compared against the DUT. An empty queue means the instance should be idle.
// ---------------------------------------------------------------------------
module tb_count_blinker;

  logic       clk;
  logic       rst;
  logic       startA;
  logic [3:0] valueA;
  logic       ledA;
  logic       busyA;
  logic       doneA;
  logic [3:0] remainingA;
  logic       startB;
  logic [3:0] valueB;
  logic       ledB;
  logic       busyB;
  logic       doneB;
  logic [3:0] remainingB;

  logic [6:0] expA[$];
  logic [6:0] expB[$];

  int checkCount;
  int passCount;
  int cycleCount;

  count_blinker dutA (
    .clk       (clk),
    .rst       (rst),
    .start     (startA),
    .value     (valueA),
    .led       (ledA),
    .busy      (busyA),
    .done      (doneA),
    .remaining (remainingA)
  );

  count_blinker #(
    .ON_CYCLES  (1),
    .OFF_CYCLES (1),
    .GAP_CYCLES (1)
  ) dutB (
    .clk       (clk),
    .rst       (rst),
    .start     (startB),
    .value     (valueB),
    .led       (ledB),
    .busy      (busyB),
    .done      (doneB),
    .remaining (remainingB)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Compares one packed {led,busy,done,remaining} sample and counts it.
  task automatic checkOutput(input string tag, input logic [6:0] observed,
                             input logic [6:0] expected);
    checkCount++;
    if (observed === expected) begin
      passCount++;
    end else begin
      $display("[TB] FAIL %s cycle %0d: got led/busy/done/rem=%b/%b/%b/%0d, want %b/%b/%b/%0d",
               tag, cycleCount, observed[6], observed[5], observed[4], observed[3:0],
               expected[6], expected[5], expected[4], expected[3:0]);
    end
  endtask

  // Builds the expected cycle-by-cycle outputs of one frame of n pulses,
  // from the cycle after the accept edge up to and including the done cycle.
  task automatic pushFrame(input int dut, input int n);
    int onC;
    int offC;
    int gapC;
    logic [6:0] seq[$];
    if (dut == 0) begin
      onC = 8; offC = 8; gapC = 16;
    end else begin
      onC = 1; offC = 1; gapC = 1;
    end
    for (int p = 1; p <= n; p++) begin
      for (int c = 0; c < onC; c++) seq.push_back({1'b1, 1'b1, 1'b0, 4'(n - p)});
      if (p < n)
        for (int c = 0; c < offC; c++) seq.push_back({1'b0, 1'b1, 1'b0, 4'(n - p)});
    end
    for (int c = 0; c < gapC; c++) seq.push_back({1'b0, 1'b1, 1'b0, 4'd0});
    seq.push_back({1'b0, 1'b0, 1'b1, 4'd0});
    foreach (seq[i]) begin
      if (dut == 0) expA.push_back(seq[i]);
      else          expB.push_back(seq[i]);
    end
  endtask

  // Advances one clock and checks both instances just after the edge.
  task automatic stepCycle();
    logic [6:0] wantA;
    logic [6:0] wantB;
    @(posedge clk);
    #1;
    cycleCount++;
    wantA = (expA.size() > 0) ? expA.pop_front() : 7'd0;
    wantB = (expB.size() > 0) ? expB.pop_front() : 7'd0;
    checkOutput("dutA", {ledA, busyA, doneA, remainingA}, wantA);
    checkOutput("dutB", {ledB, busyB, doneB, remainingB}, wantB);
  endtask

  task automatic runCycles(input int n);
    for (int i = 0; i < n; i++) stepCycle();
  endtask

  // Requests one frame on the selected instance: start is high for exactly
  // one edge, then value is scrambled to show it was captured at accept.
  task automatic applyStimulus(input int dut, input int v);
    if (dut == 0) begin
      startA = 1'b1; valueA = 4'(v);
    end else begin
      startB = 1'b1; valueB = 4'(v);
    end
    pushFrame(dut, v);
    stepCycle();
    if (dut == 0) begin
      startA = 1'b0; valueA = 4'(~v);
    end else begin
      startB = 1'b0; valueB = 4'(~v);
    end
  endtask

  initial begin
    checkCount = 0;
    passCount  = 0;
    cycleCount = 0;
    rst    = 1'b0;
    startA = 1'b1;
    valueA = 4'd5;
    startB = 1'b1;
    valueB = 4'd5;

    $display("[TB] reset held with start asserted");
    runCycles(3);
    rst    = 1'b1;
    startA = 1'b0;
    startB = 1'b0;
    runCycles(2);

    $display("[TB] basic frame, value=3");
    applyStimulus(0, 3);
    runCycles(56 + 2);

    $display("[TB] zero value frame");
    applyStimulus(0, 0);
    runCycles(16 + 2);

    $display("[TB] value=15 with one-cycle timing");
    applyStimulus(1, 15);
    runCycles(30 + 2);

    $display("[TB] start ignored while busy");
    applyStimulus(0, 2);
    runCycles(9);
    startA = 1'b1;
    valueA = 4'd9;
    stepCycle();
    startA = 1'b0;
    runCycles(30);

    $display("[TB] start held from the done cycle");
    startA = 1'b1;
    valueA = 4'd1;
    pushFrame(0, 1);
    pushFrame(0, 1);
    runCycles(25 + 24);
    startA = 1'b0;
    runCycles(1 + 2);

    $display("[TB] reset during second pulse");
    applyStimulus(0, 4);
    runCycles(17);
    rst = 1'b0;
    expA.delete();
    expB.delete();
    stepCycle();
    rst = 1'b1;
    runCycles(2);
    applyStimulus(0, 4);
    runCycles(72 + 2);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule

// File: doc/count_blinker.md
Name: count_blinker

Overview:
- Converts a 4-bit count into a train of LED pulses, so the game can show a number as N blinks.
- This is the output-side counterpart of the button-duration counter: that block turns how long a button is held into a 4-bit value; this block turns a 4-bit value back into timed physical pulses.
- Sits between the game logic (question/answer value) and a board LED.
- Frame-based: one start strobe produces one complete frame, followed by a one-cycle done pulse.

Parameters:
- ON_CYCLES, 8, clocks LED is high per pulse (1..255)
- OFF_CYCLES, 8, clocks LED is low between consecutive pulses (1..255)
- GAP_CYCLES, 16, clocks of trailing low gap after the last pulse, before done (1..255)

Ports:
- clk  input  1  clock; all logic on rising edge
- rst  input  1  synchronous reset, active-low
- start  input  1  request a frame; sampled only in IDLE
- value  input  4  number of pulses to emit (0..15); captured when start is accepted
- led  output  1  pulse train output, registered
- busy  output  1  high while a frame is in progress
- done  output  1  one-cycle pulse when a frame completes
- remaining  output  4  pulses not yet started in the current frame

Behaviour:
- Reset is synchronous on clk; rst, synchronous, active-low.
  - rst==0 at an edge forces: state=IDLE, led=0, busy=0, done=0, remaining=0, internal timer=0.
  - Reset applied mid-frame aborts the frame immediately: no done pulse, and the LED drops on that edge.
- All outputs are registered; there are no combinational paths from inputs to outputs.
- Internal timer is 8 bits and counts down. Latched pulse count is 4 bits.
- States: IDLE, ON, OFF, GAP.
- IDLE:
  - led=0, busy=0.
  - On an edge with start=1: capture value into remaining, load the timer, set busy=1.
    - value>0: go to ON with led=1 on that same edge. The LED therefore rises exactly 1 cycle after start is sampled. remaining decrements by 1 on entry to ON.
    - value==0: go to GAP with led=0.
- ON:
  - led held high for exactly ON_CYCLES cycles.
  - On expiry: if remaining>0, go to OFF; else go to GAP.
- OFF:
  - led low for exactly OFF_CYCLES cycles.
  - On expiry: go to ON, led=1, remaining decrements.
- GAP:
  - led low for exactly GAP_CYCLES cycles.
  - On expiry: go to IDLE with busy=0 and done=1 for exactly one cycle.
- done timing: done rises in the first IDLE cycle and clears on the next edge unless a new frame completes there, which is impossible for any parameter value >=1.
- Frame length, start accept edge to done edge:
  - N>0: N*ON_CYCLES + (N-1)*OFF_CYCLES + GAP_CYCLES cycles.
  - N=0: GAP_CYCLES cycles.
- busy timing: busy=1 for exactly those cycles and drops on the same edge that done rises.
- start while busy=1 is ignored and not queued.
- start asserted in the done cycle (which is an IDLE cycle) is accepted; back-to-back frames are legal.
- value is captured only at accept. Changes to value during a frame have no effect.
- Held start: if start is held high continuously, a new frame begins in every IDLE cycle, i.e. frames repeat with a 1-cycle IDLE between them.
- Wrap-around: value 15 yields 15 pulses. There is no overflow case, because remaining only decrements and stops at 0.
- remaining counts down after each pulse begins. It equals 0 during the last pulse and during GAP.

Test Plan:
- Reset check: hold rst=0 for 3 cycles with start=1, value=5 -> led=0, busy=0, done=0, remaining=0 throughout; no frame starts.
- Basic frame: defaults, value=3, start pulsed 1 cycle -> led high cycles 1-8, 17-24, 33-40 after the accept edge; GAP for 16 cycles; done=1 at cycle 57; busy high for exactly 56 cycles; remaining reads 2, 1, 0 during the three pulses.
- Zero value: value=0, start -> led never rises; busy=1 for 16 cycles; done at cycle 17.
- Max value with ON=OFF=GAP=1: value=15 -> 15 one-cycle pulses alternating with low cycles; total 30 busy cycles; done at cycle 31.
- Ignored/held start:
  - Pulse start with value=9 during the OFF phase of a value=2 frame -> exactly 2 pulses, no extra frame.
  - Then hold start=1 from the done cycle -> a new frame is accepted in the done cycle, with led rising the next cycle.
- Reset mid-frame: assert rst=0 during the 2nd ON phase of a value=4 frame -> led=0 and busy=0 on the next edge; no done pulse; after release, a new start runs a full clean frame.
